// File: rtl/lebug_uart_pkg.sv
// lebug_uart_pkg: shared receiver state encoding, defaults and the baud divider helper
package lebug_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    localparam int OVERSAMPLE_DEFAULT = 16;
    localparam logic [7:0] CMD_INSTR = 8'd42;

    function automatic int baud_div(input int clk_freq, input int baud, input int oversample);
        return (clk_freq + (baud * oversample) / 2) / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider producing one oversampling tick every DIV clocks
module uart_baud_tick
    import lebug_uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int DIV = baud_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int W   = (DIV < 2) ? 1 : $clog2(DIV);

    if (DIV < 2) begin : g_bad_div
        $error("uart_baud_tick: DIV must be at least 2");
    end

    logic [W-1:0] cnt;

    assign tick = (cnt == W'(DIV - 1));

    // count 0..DIV-1 and wrap on the tick
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt <= '0;
        else          cnt <= tick ? '0 : cnt + W'(1);
    end

endmodule

// File: rtl/uart_byte_receiver.sv
// uart_byte_receiver: 8N1 oversampling UART receiver with 3-sample majority voting
module uart_byte_receiver
    import lebug_uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       new_rx_data,
    output logic       frame_error,
    output logic       rx_busy
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] S_LO  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_MID = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_HI  = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] S_END = SW'(OVERSAMPLE - 1);

    logic          tick;
    logic          rx_meta, rx_sync;
    rx_state_t     state, state_n;
    logic [SW-1:0] sample_cnt, sample_cnt_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shift, shift_n;
    logic [1:0]    votes, votes_n;
    logic [7:0]    rx_data_n;
    logic          new_n, ferr_n;
    logic          maj;

    uart_baud_tick #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OVERSAMPLE)
    ) u_tick (
        .clk    (clk),
        .reset_n(reset_n),
        .tick   (tick)
    );

    assign maj     = (votes[1] & votes[0]) | (votes[1] & rx_sync) | (votes[0] & rx_sync);
    assign rx_busy = (state != IDLE);

    // two-flop synchronizer, idles high so reset never looks like a start bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) {rx_sync, rx_meta} <= 2'b11;
        else          {rx_sync, rx_meta} <= {rx_meta, rx};
    end

    // state and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            sample_cnt  <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            votes       <= '0;
            rx_data     <= '0;
            new_rx_data <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            state       <= state_n;
            sample_cnt  <= sample_cnt_n;
            bit_cnt     <= bit_cnt_n;
            shift       <= shift_n;
            votes       <= votes_n;
            rx_data     <= rx_data_n;
            new_rx_data <= new_n;
            frame_error <= ferr_n;
        end
    end

    // per-tick sequencing: gather samples, vote at S_HI, advance bits at S_END
    always_comb begin
        state_n      = state;
        sample_cnt_n = sample_cnt;
        bit_cnt_n    = bit_cnt;
        shift_n      = shift;
        votes_n      = votes;
        rx_data_n    = rx_data;
        new_n        = 1'b0;
        ferr_n       = 1'b0;
        if (tick) begin
            if (state == START || state == DATA || state == STOP) begin
                sample_cnt_n = (sample_cnt == S_END) ? '0 : sample_cnt + SW'(1);
                votes_n[1]   = (sample_cnt == S_LO)  ? rx_sync : votes[1];
                votes_n[0]   = (sample_cnt == S_MID) ? rx_sync : votes[0];
            end
            case (state)
                IDLE: begin
                    if (!rx_sync) begin
                        state_n      = START;
                        sample_cnt_n = '0;
                        bit_cnt_n    = '0;
                    end
                end
                START: begin
                    if (sample_cnt == S_HI && maj) begin
                        state_n      = IDLE;
                        sample_cnt_n = '0;
                    end else if (sample_cnt == S_END) begin
                        state_n = DATA;
                    end
                end
                DATA: begin
                    if (sample_cnt == S_HI) shift_n = {maj, shift[7:1]};
                    if (sample_cnt == S_END) begin
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state_n = STOP;
                    end
                end
                STOP: begin
                    if (sample_cnt == S_HI) begin
                        sample_cnt_n = '0;
                        state_n      = maj ? IDLE : WAIT_HIGH;
                        rx_data_n    = maj ? shift : rx_data;
                        new_n        = maj;
                        ferr_n       = !maj;
                    end
                end
                WAIT_HIGH: begin
                    if (rx_sync) state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_byte_receiver.sv
// tb_uart_byte_receiver: table-driven frames plus hand-written corner cases, scoreboard-checked
module tb_uart_byte_receiver;

    localparam int BITC = 64;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       new_rx_data, frame_error, rx_busy;

    always #5 clk = ~clk;

    uart_byte_receiver #(
        .CLK_FREQ  (64),
        .BAUD      (1),
        .OVERSAMPLE(16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx         (rx),
        .rx_data    (rx_data),
        .new_rx_data(new_rx_data),
        .frame_error(frame_error),
        .rx_busy    (rx_busy)
    );

    typedef struct {
        logic       err;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_err;
        logic [7:0] exp_data;
    } vec_t;

    exp_t sb[$];
    exp_t e;
    vec_t vt[6];
    int   compared = 0;
    int   mismatched = 0;
    logic new_q = 1'b0;
    logic err_q = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // every output pulse is matched against the oldest pending expectation
    always @(negedge clk) begin
        if (new_rx_data || frame_error) begin
            check("exclusive", 32'(new_rx_data & frame_error), 0);
            check("one_cycle", 32'((new_rx_data & new_q) | (frame_error & err_q)), 0);
            if (sb.size() == 0) begin
                check("unexpected_pulse", 32'({new_rx_data, frame_error}), 0);
            end else begin
                e = sb.pop_front();
                check("pulse_kind", 32'(frame_error), 32'(e.err));
                check("pulse_data", 32'(rx_data), 32'(e.data));
            end
        end
        new_q = new_rx_data;
        err_q = frame_error;
    end

    task automatic send_bit(input logic b, input logic glitch);
        rx = b;
        if (glitch) begin
            repeat (32) @(posedge clk);
            rx = 1'b0;
            repeat (4) @(posedge clk);
            rx = b;
            repeat (28) @(posedge clk);
        end else begin
            repeat (BITC) @(posedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int gbit);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            send_bit(d[i], i == gbit);
            if (i == 0) begin
                #1;
                check("busy_mid", 32'(rx_busy), 1);
            end
        end
        send_bit(stop, 1'b0);
        rx = 1'b1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_pulse(input logic err, input logic [7:0] d);
        sb.push_back('{err, d});
    endtask

    task automatic finish_seq(input string name, input logic [7:0] d);
        check({name, "_drain"}, sb.size(), 0);
        check({name, "_busy"}, 32'(rx_busy), 0);
        check({name, "_data"}, 32'(rx_data), 32'(d));
    endtask

    initial begin
        vt[0] = '{8'h2A, 1'b1, 1'b0, 8'h2A};
        vt[1] = '{8'h55, 1'b1, 1'b0, 8'h55};
        vt[2] = '{8'hA3, 1'b1, 1'b0, 8'hA3};
        vt[3] = '{8'h7E, 1'b0, 1'b1, 8'hA3};
        vt[4] = '{8'h01, 1'b1, 1'b0, 8'h01};
        vt[5] = '{8'h80, 1'b1, 1'b0, 8'h80};

        repeat (3) @(posedge clk);
        #1;
        check("rst_data", 32'(rx_data), 0);
        check("rst_new", 32'(new_rx_data), 0);
        check("rst_ferr", 32'(frame_error), 0);
        check("rst_busy", 32'(rx_busy), 0);
        reset_n = 1'b1;
        idle(2 * BITC);

        for (int i = 0; i < 6; i++) begin
            expect_pulse(vt[i].exp_err, vt[i].exp_data);
            send_frame(vt[i].data, vt[i].stop, -1);
            idle(2 * BITC);
            finish_seq("vec", vt[i].exp_data);
        end

        expect_pulse(1'b0, 8'h55);
        expect_pulse(1'b0, 8'hA3);
        send_frame(8'h55, 1'b1, -1);
        send_frame(8'hA3, 1'b1, -1);
        idle(2 * BITC);
        finish_seq("b2b", 8'hA3);

        rx = 1'b0;
        repeat (8) @(posedge clk);
        idle(2 * BITC);
        finish_seq("start_glitch", 8'hA3);

        expect_pulse(1'b0, 8'hFF);
        send_frame(8'hFF, 1'b1, 3);
        idle(2 * BITC);
        finish_seq("data_glitch", 8'hFF);

        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'(8'hC3 >> i), 1'b0);
        rx = 1'b0;
        repeat (20) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_busy", 32'(rx_busy), 0);
        check("async_rst_data", 32'(rx_data), 0);
        repeat (3) @(posedge clk);
        rx = 1'b1;
        reset_n = 1'b1;
        idle(3 * BITC);
        finish_seq("cut_frame", 8'h00);

        expect_pulse(1'b0, 8'h3C);
        send_frame(8'h3C, 1'b1, -1);
        idle(2 * BITC);
        finish_seq("after_reset", 8'h3C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_byte_receiver.md
UART_BYTE_RECEIVER -- requirements
Module: uart_byte_receiver

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, serial bit rate.
REQ-003 SHALL have parameter OVERSAMPLE, default 16, ticks per bit.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port rx  input  1  asynchronous serial line; idle high, 8N1, LSB first.
REQ-007 SHALL have port rx_data  output  8  last correctly framed byte.
REQ-008 SHALL have port new_rx_data  output  1  one-cycle pulse marking rx_data valid.
REQ-009 SHALL have port frame_error  output  1  one-cycle pulse on invalid stop bit.
REQ-010 SHALL have port rx_busy  output  1  high while in any state other than IDLE.

Function
REQ-011 SHALL pass rx through a two-flop synchronizer, both flops resetting to 1; all decoding uses the synchronized value.
REQ-012 SHALL generate tick every DIV = round(CLK_FREQ/(BAUD*OVERSAMPLE)) clocks from a free-running counter; DIV < 2 is a parameter error.
REQ-013 SHALL have states IDLE, START, DATA, STOP, WAIT_HIGH; sample_cnt 0..OVERSAMPLE-1 and bit_cnt 0..7 advance only on tick.
REQ-014 IDLE: on a tick with synchronized rx = 0, SHALL go to START with sample_cnt = 0.
REQ-015 Each bit SHALL be decided by majority of samples at sample_cnt 7, 8, 9.
REQ-016 START: majority 1 at sample_cnt 9 SHALL return to IDLE (glitch, no output); majority 0 SHALL enter DATA at end of bit (sample_cnt = 15).
REQ-017 DATA: bits SHALL be shifted in LSB first; after bit_cnt 7 completes, go to STOP.
REQ-018 STOP: at sample_cnt 9, majority 1 SHALL load rx_data, pulse new_rx_data the next clock, and return to IDLE without waiting for the stop-bit end.
REQ-019 STOP: majority 0 SHALL pulse frame_error the next clock, leave rx_data unchanged, and enter WAIT_HIGH.
REQ-020 WAIT_HIGH SHALL go to IDLE on the first tick with synchronized rx = 1.
REQ-021 new_rx_data and frame_error SHALL never be high in the same cycle and SHALL each be exactly one clock wide.
REQ-022 rx_data SHALL hold its value between frames; new_rx_data has no backpressure, and the consumer must take the byte in the pulse cycle.
REQ-023 Back-to-back frames with zero idle time SHALL be received without loss.

Reset
REQ-024 reset_n low SHALL immediately force state IDLE, all counters 0, synchronizer flops 1, rx_data 8'h00, and new_rx_data, frame_error and rx_busy 0.
REQ-025 A frame cut by reset SHALL be discarded; after release, reception resumes at the next falling edge seen in IDLE.

Structure
REQ-026 State enum, OVERSAMPLE default and the 8'd42 instrumentation-command constant SHALL live in shared package lebug_uart_pkg.
REQ-027 The tick divider SHALL be sub-module uart_baud_tick (params CLK_FREQ, BAUD, OVERSAMPLE; output tick).
REQ-028 Implementation SHALL be 120-400 lines of RTL, with no latches and no combinational path from rx to any output.

Verification (bench uses CLK_FREQ=64, BAUD=1, OVERSAMPLE=16 so DIV=4)
REQ-029 Frame 0x2A -> rx_data=0x2A, one new_rx_data pulse, no frame_error, rx_busy low afterward.
REQ-030 Back-to-back 0x55 then 0xA3, no idle gap -> two pulses with rx_data 0x55 then 0xA3.
REQ-031 rx low for 2 ticks then high -> no pulse, state back to IDLE, rx_data unchanged.
REQ-032 Frame 0x7E with stop bit 0 -> one frame_error pulse, no new_rx_data, rx_data keeps prior 0xA3; line high, then 0x01 -> rx_data=0x01.
REQ-033 One-tick low glitch at sample 8 of data bit 3 of 0xFF -> rx_data=0xFF (majority correction).
REQ-034 reset_n pulsed low during bit 4 of 0xC3, then a clean 0x3C -> no output for 0xC3, rx_data=0x3C with one pulse.
